// File: rtl/ahb_slave_pkg.sv
// Shared types and helpers for the AHB responder memory.
// Transfer/response encodings, size codes, FSM states, byte-lane mask.
package ahb_slave_pkg;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [1:0] {
        HR_OKAY  = 2'b00,
        HR_ERROR = 2'b01
    } hresp_t;

    localparam logic [2:0] BYTE  = 3'd0;
    localparam logic [2:0] HALF  = 3'd1;
    localparam logic [2:0] WORD  = 3'd2;
    localparam logic [2:0] DWORD = 3'd3;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        ERR1 = 2'b10,
        ERR2 = 2'b11
    } state_t;

    // Little-endian lane mask for an aligned transfer of 2**size bytes.
    function automatic logic [7:0] f_byte_en(
        input logic [2:0] size,
        input logic [2:0] lsb
    );
        logic [7:0] m;
        case (size)
            BYTE:    m = 8'h01;
            HALF:    m = 8'h03;
            WORD:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m << lsb;
    endfunction

endpackage

// File: rtl/ahb_slave_mem_array.sv
// Single-port storage with per-byte write enables.
// Read is asynchronous; write commits on the rising clock edge.
module ahb_slave_mem_array #(
    parameter int MEM_WORDS  = 256,
    parameter int DATA_WIDTH = 32
) (
    input  logic                         i_clk,
    input  logic                         i_we,
    input  logic [DATA_WIDTH/8-1:0]      i_be,
    input  logic [$clog2(MEM_WORDS)-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0]        i_wdata,
    output logic [DATA_WIDTH-1:0]        o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];

    // Byte-lane write into the addressed word.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB responder memory for one slave address window.
// OKAY transfers with programmable wait states, two-cycle ERROR otherwise.
module ahb_slave_mem
    import ahb_slave_pkg::*;
#(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int START_ADDRESS = 0,
    parameter int END_ADDRESS   = 1023,
    parameter int WAIT_STATES   = 0,
    parameter int MEM_WORDS     =
        (END_ADDRESS - START_ADDRESS + 1) / (DATA_WIDTH / 8)
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic [1:0]            HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA
);

    localparam int NB  = DATA_WIDTH / 8;
    localparam int LSB = $clog2(NB);
    localparam int IW  = $clog2(MEM_WORDS);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_nxt;
    logic                  r_dphase;
    logic                  r_err;
    logic                  r_write;
    logic [2:0]            r_size;
    logic [ADDR_WIDTH-1:0] r_addr;

    logic                  w_take;
    logic                  w_err;
    logic [7:0]            w_nbytes;
    logic [ADDR_WIDTH-1:0] w_amask;
    logic                  w_ok_done;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_off;
    logic [IW-1:0]         w_idx;
    logic [2:0]            w_lsb;
    logic [7:0]            w_be8;
    logic [NB-1:0]         w_be;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_unused;

    // Address phases are only taken while this slave is not stalling.
    assign w_take = HSEL & HREADY & HTRANS[1] & HREADYOUT;

    assign w_nbytes = 8'd1 << HSIZE;
    assign w_amask  = {{(ADDR_WIDTH-8){1'b0}}, w_nbytes - 8'd1};
    assign w_err    = (HADDR < ADDR_WIDTH'(START_ADDRESS))
                    | (HADDR > ADDR_WIDTH'(END_ADDRESS))
                    | ((HADDR & w_amask) != '0)
                    | (w_nbytes > 8'(NB));

    // The completing OKAY cycle is the IDLE cycle that ends a data phase.
    assign w_ok_done = (r_state == IDLE) & r_dphase & ~r_err;
    assign w_we      = w_ok_done & r_write & HRESETn;

    assign w_off = r_addr - ADDR_WIDTH'(START_ADDRESS);
    assign w_idx = w_off[LSB +: IW];
    assign w_lsb = 3'(r_addr[LSB-1:0]);
    assign w_be8 = f_byte_en(r_size, w_lsb);
    assign w_be  = w_be8[NB-1:0];

    assign w_unused = ^{HBURST, HTRANS[0], w_off, w_be8};

    ahb_slave_mem_array #(
        .MEM_WORDS  (MEM_WORDS),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .i_clk   (HCLK),
        .i_we    (w_we),
        .i_be    (w_be),
        .i_addr  (w_idx),
        .i_wdata (HWDATA),
        .o_rdata (w_rdata)
    );

    // State, wait counter and captured address-phase controls.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_dphase <= 1'b0;
            r_err    <= 1'b0;
            r_write  <= 1'b0;
            r_size   <= '0;
            r_addr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_take) begin
                r_dphase <= 1'b1;
                r_err    <= w_err;
                r_write  <= HWRITE;
                r_size   <= HSIZE;
                r_addr   <= HADDR;
            end else if (HREADYOUT) begin
                r_dphase <= 1'b0;
            end
        end
    end

    // Next state, wait countdown and bus responses.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        HREADYOUT   = 1'b1;
        HRESP       = HR_OKAY;
        HRDATA      = '0;
        case (r_state)
            IDLE, ERR2: begin
                if (r_state == ERR2) begin
                    HRESP = HR_ERROR;
                end
                w_state_nxt = IDLE;
                if (w_take) begin
                    if (w_err) begin
                        w_state_nxt = ERR1;
                    end else if (WAIT_STATES != 0) begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = 4'(WAIT_STATES);
                    end
                end
            end
            WAIT: begin
                HREADYOUT = 1'b0;
                if (r_cnt <= 4'd1) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ERR1: begin
                HREADYOUT   = 1'b0;
                HRESP       = HR_ERROR;
                w_state_nxt = ERR2;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        if (w_ok_done && !r_write) begin
            HRDATA = w_rdata;
        end
    end

endmodule
